// File: rtl/dial_tracker.sv
// Circular dial tracker: one rotation command per handshake, W-cycle restoring
// divider for n / MOD, then a one-cycle position/zero-hit update.
module dial_tracker #(
  parameter int W     = 32,
  parameter int MOD   = 100,
  parameter int START = 50,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   dir,
  input  logic [W-1:0]           n,
  input  logic                   mode,
  output logic                   res_valid,
  output logic [$clog2(MOD)-1:0] pos_out,
  output logic [CNT_W-1:0]       zero_count,
  output logic                   busy
);

  localparam int PW = $clog2(MOD);
  localparam int IW = W + 1;
  localparam int SW = ((CNT_W > IW) ? CNT_W : IW) + 1;
  localparam int CW = $clog2(W + 1);

  localparam logic [W-1:0]     MOD_W    = W'(MOD);
  localparam logic [IW-1:0]    MOD_I    = IW'(MOD);
  localparam logic [PW-1:0]    START_P  = PW'(START);
  localparam logic [CW-1:0]    LAST_CNT = CW'(W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    UPD  = 2'd2
  } state_t;

  state_t           state_r;
  logic             dir_r;
  logic             mode_r;
  logic [W-1:0]     quo_r;
  logic [W-1:0]     rem_r;
  logic [CW-1:0]    cnt_r;
  logic [PW-1:0]    pos_r;
  logic [CNT_W-1:0] count_r;
  logic             res_valid_r;
  logic             busy_r;
  logic             in_ready_r;

  logic [W-1:0]     trial_s;
  logic [W-1:0]     rem_next_s;
  logic [W-1:0]     quo_next_s;
  logic [IW-1:0]    p_s;
  logic [IW-1:0]    r_s;
  logic [IW-1:0]    sum_s;
  logic             wrap_s;
  logic [IW-1:0]    new_s;
  logic [IW-1:0]    inc_s;
  logic [SW-1:0]    total_s;
  logic [PW-1:0]    pos_next_s;
  logic [CNT_W-1:0] count_next_s;

  // One restoring-division step: the remainder stays below MOD, so W bits suffice.
  always_comb begin
    trial_s = {rem_r[W-2:0], quo_r[W-1]};
    if (trial_s >= MOD_W) begin
      rem_next_s = trial_s - MOD_W;
      quo_next_s = {quo_r[W-2:0], 1'b1};
    end else begin
      rem_next_s = trial_s;
      quo_next_s = {quo_r[W-2:0], 1'b0};
    end
  end

  // New position and saturating zero-hit count from the finished quotient/remainder.
  always_comb begin
    p_s    = IW'(pos_r);
    r_s    = IW'(rem_r);
    sum_s  = p_s + r_s;
    wrap_s = (sum_s >= MOD_I);
    if (dir_r) begin
      if (wrap_s) begin
        new_s = sum_s - MOD_I;
      end else begin
        new_s = sum_s;
      end
    end else begin
      if (r_s > p_s) begin
        new_s = p_s + MOD_I - r_s;
      end else begin
        new_s = p_s - r_s;
      end
    end
    if (!mode_r) begin
      inc_s = IW'(new_s == {IW{1'b0}});
    end else if (dir_r) begin
      inc_s = IW'(quo_r) + IW'(wrap_s);
    end else begin
      inc_s = IW'(quo_r) + IW'((p_s != {IW{1'b0}}) && (r_s >= p_s));
    end
    total_s    = SW'(count_r) + SW'(inc_s);
    pos_next_s = new_s[PW-1:0];
    if (total_s > SW'(CNT_MAX)) begin
      count_next_s = CNT_MAX;
    end else begin
      count_next_s = total_s[CNT_W-1:0];
    end
  end

  // Control FSM, divider registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pos_r       <= START_P;
      count_r     <= {CNT_W{1'b0}};
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      res_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            dir_r      <= dir;
            mode_r     <= mode;
            quo_r      <= n;
            rem_r      <= {W{1'b0}};
            cnt_r      <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= DIV;
          end
        end
        DIV: begin
          quo_r <= quo_next_s;
          rem_r <= rem_next_s;
          if (cnt_r == LAST_CNT) begin
            state_r <= UPD;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        UPD: begin
          pos_r       <= pos_next_s;
          count_r     <= count_next_s;
          res_valid_r <= 1'b1;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign res_valid  = res_valid_r;
  assign pos_out    = pos_r;
  assign zero_count = count_r;

endmodule

// File: tb/tb_dial_tracker.sv
// Scoreboard bench for dial_tracker: a default instance plus a CNT_W=4
// instance for saturation, checked against an arithmetic click-count model.
module tb_dial_tracker;
  localparam int W     = 32;
  localparam int MOD   = 100;
  localparam int START = 50;
  localparam int CW0   = 32;
  localparam int CW1   = 4;
  localparam int PW    = $clog2(MOD);

  typedef struct {
    longint pos;
    longint cnt;
    longint acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic iv0, dir0, mode0, rdy0, rv0, busy0;
  logic [W-1:0] n0;
  logic [PW-1:0] pos0;
  logic [CW0-1:0] zc0;
  logic iv1, dir1, mode1, rdy1, rv1, busy1;
  logic [W-1:0] n1;
  logic [PW-1:0] pos1;
  logic [CW1-1:0] zc1;

  dial_tracker #(.W(W), .MOD(MOD), .START(START), .CNT_W(CW0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .dir(dir0), .n(n0),
    .mode(mode0), .res_valid(rv0), .pos_out(pos0), .zero_count(zc0), .busy(busy0));

  dial_tracker #(.W(W), .MOD(MOD), .START(START), .CNT_W(CW1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .dir(dir1), .n(n1),
    .mode(mode1), .res_valid(rv1), .pos_out(pos1), .zero_count(zc1), .busy(busy1));

  int errors = 0;
  int checks = 0;
  longint cyc = 0;
  int pulses1 = 0;
  longint mpos[2];
  longint mcount[2];
  longint cmax[2];
  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: count the clicks that land on 0 directly from the rotation.
  function automatic void model(input int sel, input bit d, input longint nn, input bit m,
                                output longint np, output longint nc);
    longint p, hits, inc;
    p = mpos[sel];
    if (d) begin
      np   = (p + nn) % MOD;
      hits = (p + nn) / MOD;
    end else begin
      np = ((p - (nn % MOD)) + MOD) % MOD;
      if (p == 0) hits = nn / MOD;
      else if (nn >= p) hits = (nn - p) / MOD + 1;
      else hits = 0;
    end
    inc = m ? hits : ((np == 0) ? 1 : 0);
    nc  = mcount[sel] + inc;
    if (nc > cmax[sel]) nc = cmax[sel];
    mpos[sel]   = np;
    mcount[sel] = nc;
  endfunction

  task automatic issue(input int sel, input bit d, input longint nn, input bit m);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!((sel == 0) ? rdy0 : rdy1)) begin
      if (sel == 0) begin dir0 = 1'($urandom_range(0, 1)); n0 = $urandom; mode0 = 1'($urandom_range(0, 1)); end
      else begin dir1 = 1'($urandom_range(0, 1)); n1 = $urandom; mode1 = 1'($urandom_range(0, 1)); end
      guard++;
      if (guard > 200) begin
        chk("in_ready_timeout", 0, 1);
        return;
      end
      @(negedge clk);
    end
    if (sel == 0) begin iv0 = 1'b1; dir0 = d; n0 = nn[W-1:0]; mode0 = m; end
    else begin iv1 = 1'b1; dir1 = d; n1 = nn[W-1:0]; mode1 = m; end
    e.acc = cyc;
    model(sel, d, nn, m, e.pos, e.cnt);
    if (sel == 0) q0.push_back(e);
    else q1.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle_drain();
    int guard;
    @(negedge clk);
    iv0 = 1'b0;
    iv1 = 1'b0;
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) chk("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    iv0 = 1'b0;
    iv1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      mpos[i]   = START;
      mcount[i] = 0;
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rv0) begin
      if (q0.size() == 0) chk("dut0_unexpected_res_valid", 1, 0);
      else begin
        e = q0.pop_front();
        chk("dut0_pos", longint'(pos0), e.pos);
        chk("dut0_count", longint'(zc0), e.cnt);
        chk("dut0_latency", cyc - e.acc, W + 2);
      end
    end
    if (!rst && rv1) begin
      pulses1++;
      if (q1.size() == 0) chk("dut1_unexpected_res_valid", 1, 0);
      else begin
        e = q1.pop_front();
        chk("dut1_pos", longint'(pos1), e.pos);
        chk("dut1_count", longint'(zc1), e.cnt);
        chk("dut1_latency", cyc - e.acc, W + 2);
      end
    end
  end

  bit     sd[10]    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  longint sn[10]    = '{68, 30, 48, 5, 60, 55, 1, 99, 14, 82};
  longint m1cnt[10] = '{1, 1, 2, 2, 3, 4, 4, 5, 5, 6};
  bit     bd[5]     = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  longint bn[5]     = '{1000, 50, 100, 0, 0};
  bit     bm[5]     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  longint bpos[5]   = '{50, 0, 0, 0, 0};
  longint bcnt[5]   = '{10, 11, 12, 12, 13};

  initial begin
    cmax[0] = 64'h0000_0000_FFFF_FFFF;
    cmax[1] = 15;
    rst = 1'b1;
    iv0 = 1'b0; dir0 = 1'b0; n0 = '0; mode0 = 1'b0;
    iv1 = 1'b0; dir1 = 1'b0; n1 = '0; mode1 = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    repeat (5) @(negedge clk);
    chk("reset_pos", longint'(pos0), 50);
    chk("reset_count", longint'(zc0), 0);
    chk("reset_res_valid", longint'(rv0), 0);
    chk("reset_in_ready", longint'(rdy0), 1);
    chk("reset_busy", longint'(busy0), 0);

    // mode 0 sequence, back to back
    for (int i = 0; i < 10; i++) begin
      issue(0, sd[i], sn[i], 1'b0);
      if (i == 0) begin
        @(negedge clk);
        chk("busy_in_flight", longint'(busy0), 1);
        chk("not_ready_in_flight", longint'(rdy0), 0);
      end
    end
    idle_drain();
    chk("mode0_final_pos", longint'(pos0), 32);
    chk("mode0_final_count", longint'(zc0), 3);

    // mode 1 sequence, checking each intermediate count
    do_reset();
    for (int i = 0; i < 10; i++) begin
      issue(0, sd[i], sn[i], 1'b1);
      idle_drain();
      chk($sformatf("mode1_count_%0d", i), longint'(zc0), m1cnt[i]);
    end
    chk("mode1_final_pos", longint'(pos0), 32);

    // boundaries: full laps, landing on 0, start at 0, n=0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      issue(0, bd[i], bn[i], bm[i]);
      idle_drain();
      chk($sformatf("boundary_pos_%0d", i), longint'(pos0), bpos[i]);
      chk($sformatf("boundary_count_%0d", i), longint'(zc0), bcnt[i]);
    end

    // abort during DIV
    do_reset();
    issue(0, 1'b1, 1000, 1'b1);
    @(negedge clk);
    iv0 = 1'b0;
    repeat (9) @(negedge clk);
    do_reset();
    chk("abort_in_ready", longint'(rdy0), 1);
    chk("abort_busy", longint'(busy0), 0);
    chk("abort_pos", longint'(pos0), 50);
    chk("abort_count", longint'(zc0), 0);
    issue(0, 1'b0, 5, 1'b0);
    idle_drain();
    chk("after_abort_pos", longint'(pos0), 45);

    // randomized commands, back to back
    for (int i = 0; i < 40; i++) begin
      longint rn;
      if ($urandom_range(0, 3) == 0) rn = longint'($urandom);
      else rn = longint'($urandom_range(0, 450));
      issue(0, 1'($urandom_range(0, 1)), rn, 1'($urandom_range(0, 1)));
    end
    idle_drain();

    // saturation on the narrow counter, garbage held on in_valid while busy
    do_reset();
    pulses1 = 0;
    issue(1, 1'b1, 2000, 1'b1);
    issue(1, 1'b0, 7, 1'b1);
    idle_drain();
    repeat (50) @(negedge clk);
    chk("sat_count", longint'(zc1), 15);
    chk("sat_pos", longint'(pos1), 43);
    chk("sat_pulses", longint'(pulses1), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
